// File: rtl/sfr_pkg.sv
// Shared SFR address map and arbiter state encoding.
package sfr_pkg;

  localparam int unsigned SFR_AW = 8;
  localparam int unsigned SFR_DW = 8;

  typedef enum logic [SFR_AW-1:0] {
    NOP        = 8'd0,
    CTRL       = 8'd1,
    STATUS     = 8'd2,
    PWM_CTRL   = 8'd3,
    PWM_PERIOD = 8'd4,
    PWM_DUTY   = 8'd5,
    TMR_CTRL   = 8'd6,
    TMR_LOAD   = 8'd7,
    TMR_COUNT  = 8'd8,
    SIN        = 8'd9,
    SOUT       = 8'd10
  } sfr_addr_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/sfr_arbiter.sv
// Two-port round-robin arbiter serialising CPU and host/debug accesses onto one SFR bus.
module sfr_arbiter
  import sfr_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [SFR_AW-1:0] a_addr,
  input  logic [SFR_DW-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_done,
  output logic [SFR_DW-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [SFR_AW-1:0] b_addr,
  input  logic [SFR_DW-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_done,
  output logic [SFR_DW-1:0] b_rdata,
  output logic [SFR_AW-1:0] sfr_addr,
  output logic [SFR_DW-1:0] sfr_write_val,
  output logic              sfr_write_valid,
  input  logic [SFR_DW-1:0] sfr_read_val
);

  localparam int unsigned CNT_W = 2;

  arb_state_e       state;
  logic [CNT_W-1:0] hold_cnt;
  logic             prio_b;
  logic             owner_b;
  logic             lat_we;
  logic             win_a;
  logic             win_b;

  // Grant is decided in the IDLE cycle the request is seen; B wins a tie only when A was served last.
  assign win_a = nrst && (state == IDLE) && a_req && (!b_req || !prio_b);
  assign win_b = nrst && (state == IDLE) && b_req && !win_a;
  assign a_gnt = win_a;
  assign b_gnt = win_b;

  // sfr_addr/sfr_write_val double as the transaction latch until the return to IDLE.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state           <= IDLE;
      hold_cnt        <= '0;
      prio_b          <= 1'b0;
      owner_b         <= 1'b0;
      lat_we          <= 1'b0;
      sfr_addr        <= NOP;
      sfr_write_val   <= '0;
      sfr_write_valid <= 1'b0;
      a_done          <= 1'b0;
      b_done          <= 1'b0;
      a_rdata         <= '0;
      b_rdata         <= '0;
    end else begin
      a_done          <= 1'b0;
      b_done          <= 1'b0;
      sfr_write_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (win_a || win_b) begin
            state         <= SETUP;
            owner_b       <= win_b;
            prio_b        <= win_a;
            lat_we        <= win_a ? a_we    : b_we;
            sfr_addr      <= win_a ? a_addr  : b_addr;
            sfr_write_val <= win_a ? a_wdata : b_wdata;
          end
        end
        SETUP: begin
          state           <= STROBE;
          sfr_write_valid <= lat_we;
        end
        STROBE: begin
          state    <= HOLD;
          hold_cnt <= CNT_W'(HOLD_CYCLES - 1);
          if (!lat_we) begin
            if (owner_b) b_rdata <= sfr_read_val;
            else         a_rdata <= sfr_read_val;
          end
          if (HOLD_CYCLES == 1) begin
            a_done <= !owner_b;
            b_done <= owner_b;
          end
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            state         <= IDLE;
            sfr_addr      <= NOP;
            sfr_write_val <= '0;
          end else begin
            hold_cnt <= hold_cnt - CNT_W'(1);
            if (hold_cnt == CNT_W'(1)) begin
              a_done <= !owner_b;
              b_done <= owner_b;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sfr_arbiter.md
SFR_ARBITER -- requirements
Module: sfr_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 1: SFR address/data hold cycles after the write strobe falls (1..4).
REQ-002 clk  in  1  single system clock; all logic on rising edge.
REQ-003 nrst  in  1  reset, asynchronous, active-low.
REQ-004 a_req, a_we  in  1,1  port A (CPU) request; 1=write, 0=read.
REQ-005 a_addr, a_wdata  in  8,8  port A SFR address, write data.
REQ-006 a_gnt, a_done  out  1,1  port A one-cycle grant pulse, one-cycle completion pulse.
REQ-007 a_rdata  out  8  port A read data, valid while a_done=1.
REQ-008 b_req, b_we, b_addr, b_wdata, b_gnt, b_done, b_rdata: identical set for port B (host/debug).
REQ-009 sfr_addr  out  8  address to SFR block.
REQ-010 sfr_write_val  out  8  write data to SFR block.
REQ-011 sfr_write_valid  out  1  write strobe; SFR captures on its rising edge.
REQ-012 sfr_read_val  in  8  combinational read data from SFR block.

Function
REQ-013 FSM states IDLE, SETUP, STROBE, HOLD; one transaction in flight at a time.
REQ-014 IDLE, any req high: pick winner, latch we/addr/wdata, pulse winner gnt that cycle, go SETUP.
REQ-015 Both req in same IDLE cycle: grant the port not served last (round-robin); after reset A has priority.
REQ-016 Single requester: granted in first IDLE cycle it is seen, regardless of pointer.
REQ-017 SETUP (1 cycle): sfr_addr/sfr_write_val driven from latch, sfr_write_valid=0.
REQ-018 STROBE (1 cycle): sfr_write_valid=1 for writes only; reads capture sfr_read_val into rdata register at end of cycle.
REQ-019 HOLD (HOLD_CYCLES cycles): sfr_write_valid=0, address/data unchanged; done pulse for winner in last HOLD cycle; then IDLE.
REQ-020 Grant-to-done latency = 2+HOLD_CYCLES cycles; new grant possible in the cycle after done (throughput 1 txn / 3+HOLD_CYCLES).
REQ-021 Requests arriving outside IDLE wait; req need only be held until its gnt; req deasserted before gnt is dropped silently.
REQ-022 rdata of a port updates only on that port's read; holds last value otherwise; writes return no data.
REQ-023 sfr_write_valid at most one 1-cycle pulse per write transaction, never for reads, never in IDLE.
REQ-024 IDLE outputs: sfr_addr=0 (NOP), sfr_write_val=0, sfr_write_valid=0.
REQ-025 Round-robin pointer updates at grant time only.

Reset
REQ-026 nrst low: state IDLE, all gnt/done 0, sfr_write_valid 0, sfr_addr/write_val 0, both rdata 0, pointer favours A -- immediately, without clock.
REQ-027 Reset mid-transaction aborts it: no done, no further strobe; transaction not replayed after release.

Structure
REQ-028 Shared package sfr_pkg holds the SFR address enum (NOP..SOUT) and the arbiter state typedef.
REQ-029 Single module; no sub-module required.

Verification
REQ-030 A write addr=4 (PWM_PERIOD) data=0x80 -> a_gnt cycle N, strobe only at N+2, addr=4 held N+1..N+3, a_done N+3.
REQ-031 A and B request together after reset -> A granted first, B granted cycle after a_done; next simultaneous pair grants A again (B was last).
REQ-032 B read addr=9 with sfr_read_val=0x5A -> b_done 3 cycles after b_gnt, b_rdata=0x5A, a_rdata unchanged, no strobe.
REQ-033 HOLD_CYCLES=3, write -> done 5 cycles after grant; address stable 3 cycles after strobe falls.
REQ-034 nrst low during STROBE -> sfr_write_valid 0 immediately, no done; after release, IDLE with zero outputs.
REQ-035 Back-to-back A writes with a_req held high -> grants every 4 cycles, exactly one strobe per write.
